// File: rtl/multiplier_module_1_if.sv
// Request/response bundle shared by the sequential multiplier and its requester.
// Uses the same start/done/busy handshake as the signed divider.
interface multiplier_module_1_if #(
    parameter int WIDTH = 8
);
    logic                   start_sig;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   done_sig;
    logic                   busy_sig;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start_sig, multiplicand, multiplier,
        input  done_sig, busy_sig, product
    );

    modport slave (
        input  start_sig, multiplicand, multiplier,
        output done_sig, busy_sig, product
    );
endinterface

// File: rtl/multiplier_module_1.sv
// Signed sequential multiplier: the operands are turned into magnitudes, then
// multiplied by shift-add over WIDTH cycles, and finally the sign is applied.
module multiplier_module_1 #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    multiplier_module_1_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   mag_a_reg, mag_a_next;
    logic [WIDTH-1:0]   mag_b_reg, mag_b_next;
    logic               sign_reg, sign_next;
    logic [PW-1:0]      acc_reg, acc_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [PW-1:0]      product_reg, product_next;
    logic               done_reg, done_next;

    logic [IW-1:0]      cnt_idx;
    logic [PW-1:0]      shifted_a [WIDTH];

    // Each table entry is |A| already positioned for the bit of |B| it serves.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            assign shifted_a[gi] = {{WIDTH{1'b0}}, mag_a_reg} << gi;
        end
    endgenerate

    assign cnt_idx = cnt_reg[IW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            mag_a_reg   <= '0;
            mag_b_reg   <= '0;
            sign_reg    <= 1'b0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mag_a_reg   <= mag_a_next;
            mag_b_reg   <= mag_b_next;
            sign_reg    <= sign_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mag_a_next   = mag_a_reg;
        mag_b_next   = mag_b_reg;
        sign_next    = sign_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start_sig) begin
                    // The most-negative value negates to itself, which reads
                    // correctly as an unsigned magnitude.
                    mag_a_next = bus.multiplicand[WIDTH-1] ?
                                 (~bus.multiplicand + WIDTH'(1)) : bus.multiplicand;
                    mag_b_next = bus.multiplier[WIDTH-1] ?
                                 (~bus.multiplier + WIDTH'(1)) : bus.multiplier;
                    sign_next  = bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (!bus.start_sig) begin
                    state_next = IDLE;
                end else if (cnt_reg == CW'(WIDTH)) begin
                    state_next = FIX;
                end else begin
                    if (mag_b_reg[cnt_idx]) begin
                        acc_next = acc_reg + shifted_a[cnt_idx];
                    end
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            FIX: begin
                if (!bus.start_sig) begin
                    state_next = IDLE;
                end else begin
                    product_next = sign_reg ? (~acc_reg + PW'(1)) : acc_reg;
                    done_next    = 1'b1;
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.done_sig = done_reg;
    assign bus.busy_sig = (state_reg != IDLE);
    assign bus.product  = product_reg;
endmodule

// File: tb/tb_multiplier_module_1.sv
// Bench for multiplier_module_1: vector table, random operands, and the
// back-to-back, abort and mid-operation reset sequences.
module tb_multiplier_module_1;
    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 2;

    logic clk;
    logic rst;

    multiplier_module_1_if #(.WIDTH(WIDTH)) bus ();

    multiplier_module_1 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t         vecs [9];
    logic [15:0]  sb [$];
    int           tests_run;
    int           tests_failed;

    task automatic check(input string name, input longint act, input longint exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        logic [15:0] exp;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s: done_sig with empty scoreboard, product 0x%0h", name, bus.product);
        end else begin
            exp = sb.pop_front();
            check({name, " product"}, bus.product, exp);
            $display("[TB] %s: product=0x%04h expected=0x%04h", name, bus.product, exp);
        end
    endtask

    // Advances edge index e until done_sig is seen or the budget expires.
    task automatic wait_done(inout int e, output bit seen);
        seen = 1'b0;
        while (e < 60) begin
            @(posedge clk); #1;
            e++;
            if (e == 3) begin
                bus.multiplicand = 8'($urandom);
                bus.multiplier   = 8'($urandom);
            end
            if (bus.done_sig) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string name);
        int e;
        bit seen;
        @(negedge clk);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start_sig    = 1'b1;
        sb.push_back(exp);
        e = -1;
        wait_done(e, seen);
        check({name, " latency"}, e, LAT);
        if (seen) pop_check(name);
        else void'(sb.pop_front());
        bus.start_sig = 1'b0;
        @(posedge clk); #1;
        check({name, " done pulse width"}, bus.done_sig, 0);
    endtask

    initial begin
        int          e;
        bit          seen;
        int          done_count;
        logic [7:0]  ra, rb;
        logic signed [15:0] rp;

        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{8'd9,    8'd6,    16'h0036, "9x6"};
        vecs[1] = '{8'd9,    8'hFA,   16'hFFCA, "9x-6"};
        vecs[2] = '{8'hF7,   8'd6,    16'hFFCA, "-9x6"};
        vecs[3] = '{8'hF7,   8'hFA,   16'h0036, "-9x-6"};
        vecs[4] = '{8'h80,   8'h80,   16'h4000, "-128x-128"};
        vecs[5] = '{8'h80,   8'h7F,   16'hC080, "-128x127"};
        vecs[6] = '{8'h7F,   8'h7F,   16'h3F01, "127x127"};
        vecs[7] = '{8'h00,   8'hFB,   16'h0000, "0x-5"};
        vecs[8] = '{8'hFF,   8'd1,    16'hFFFF, "-1x1"};

        rst              = 1'b1;
        bus.start_sig    = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset product", bus.product, 0);
        check("reset done_sig", bus.done_sig, 0);
        check("reset busy_sig", bus.busy_sig, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle busy_sig", bus.busy_sig, 0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        end

        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rp = $signed(ra) * $signed(rb);
            run_op(ra, rb, rp, "random");
        end

        // Back-to-back: start stays high across the first done_sig.
        @(negedge clk);
        bus.multiplicand = 8'h00;
        bus.multiplier   = 8'hFB;
        bus.start_sig    = 1'b1;
        sb.push_back(16'h0000);
        e = -1;
        wait_done(e, seen);
        check("b2b first latency", e, LAT);
        if (seen) pop_check("b2b first 0x-5");
        else void'(sb.pop_front());
        bus.multiplicand = 8'd9;
        bus.multiplier   = 8'd6;
        sb.push_back(16'h0036);
        wait_done(e, seen);
        check("b2b second edge", e, 2 * LAT + 2);
        if (seen) pop_check("b2b second 9x6");
        else void'(sb.pop_front());
        bus.start_sig = 1'b0;
        @(posedge clk); #1;
        check("b2b done pulse width", bus.done_sig, 0);

        // Abort: drop start during the fourth CALC cycle.
        @(negedge clk);
        bus.multiplicand = 8'd5;
        bus.multiplier   = 8'd5;
        bus.start_sig    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        check("abort busy before drop", bus.busy_sig, 1);
        bus.start_sig = 1'b0;
        @(posedge clk); #1;
        check("abort busy_sig", bus.busy_sig, 0);
        check("abort done_sig", bus.done_sig, 0);
        check("abort product held", bus.product, 16'h0036);
        done_count = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.done_sig) done_count++;
        end
        check("abort no done", done_count, 0);
        $display("[TB] abort 5x5: product=0x%04h busy=%0d", bus.product, bus.busy_sig);
        run_op(8'd3, 8'd3, 16'h0009, "restart 3x3");

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.multiplicand = 8'd7;
        bus.multiplier   = 8'd7;
        bus.start_sig    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("midreset product", bus.product, 0);
        check("midreset done_sig", bus.done_sig, 0);
        check("midreset busy_sig", bus.busy_sig, 0);
        $display("[TB] reset mid-CALC: product=0x%04h busy=%0d", bus.product, bus.busy_sig);
        @(negedge clk);
        bus.start_sig = 1'b0;
        rst = 1'b0;
        run_op(8'd3, 8'hFD, 16'hFFF7, "post-reset 3x-3");

        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
